// File: rtl/csa_csum_fold_if.sv
// Beat/result bundle between the 6:3 carry-save compressor, the checksum folder
// and the checksum insert/verify consumer.
interface csa_csum_fold_if #(
    parameter int unsigned W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_sum;
    logic [W-1:0] in_carry;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_csum;
    logic         out_ovf;

    modport master (
        output in_valid, in_sum, in_carry, in_last, out_ready,
        input  in_ready, out_valid, out_csum, out_ovf
    );

    modport slave (
        input  in_valid, in_sum, in_carry, in_last, out_ready,
        output in_ready, out_valid, out_csum, out_ovf
    );
endinterface

// File: rtl/csa_csum_fold.sv
// Accumulates carry-save beats of a packet in binary, then folds end-around to a 16-bit
// ones' complement checksum. Define CSA_CSUM_FOLD_ZERO_MAP_EN to report 0x0000 as 0xFFFF.
module csa_csum_fold #(
    parameter int unsigned W     = 32,
    parameter int unsigned ACC_W = 48
) (
    input  logic              clk,
    input  logic              rst,
    csa_csum_fold_if.slave    bus_io
);
    localparam int unsigned NCh  = (ACC_W + 15) / 16;
    localparam int unsigned CntW = ACC_W - W - 1;
    localparam int unsigned MaxB = 2 ** (ACC_W - W - 2);

    typedef enum logic [1:0] {StAcc, StFold, StOut} state_e;

    state_e             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CntW-1:0]    cnt_q;
    logic               ovf_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [15:0]        out_csum_q;
    logic               out_ovf_q;

    logic [ACC_W-1:0]   beat_w;
    logic [NCh*16-1:0]  acc_pad_w;
    logic [ACC_W-1:0]   fold_w;
    logic [15:0]        csum_w;

    // Carry vector carries weight 2, so it enters shifted left by one.
    assign beat_w = ACC_W'(bus_io.in_sum) + ACC_W'({bus_io.in_carry, 1'b0});

    always_comb begin
        acc_pad_w = '0;
        acc_pad_w[ACC_W-1:0] = acc_q;
        fold_w = '0;
        for (int i = 0; i < int'(NCh); i++) begin
            fold_w = fold_w + ACC_W'(acc_pad_w[i*16 +: 16]);
        end
    end

    always_comb begin
        csum_w = ~acc_q[15:0];
`ifdef CSA_CSUM_FOLD_ZERO_MAP_EN
        if (csum_w == 16'h0000) begin
            csum_w = 16'hFFFF;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StAcc;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_csum_q  <= 16'h0000;
            out_ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StAcc: begin
                    if (bus_io.in_valid) begin
                        acc_q <= acc_q + beat_w;
                        if (cnt_q == CntW'(MaxB)) begin
                            ovf_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if (bus_io.in_last) begin
                            state_q    <= StFold;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                StFold: begin
                    if (acc_q[ACC_W-1:16] == '0) begin
                        state_q     <= StOut;
                        out_valid_q <= 1'b1;
                        out_csum_q  <= csum_w;
                        out_ovf_q   <= ovf_q;
                    end else begin
                        acc_q <= fold_w;
                    end
                end
                StOut: begin
                    if (bus_io.out_ready) begin
                        state_q     <= StAcc;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        ovf_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= StAcc;
            endcase
        end
    end

    assign bus_io.in_ready  = in_ready_q;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_csum  = out_csum_q;
    assign bus_io.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_csa_csum_fold.sv
// Directed bench for csa_csum_fold: a packet-level arithmetic model checked every cycle,
// plus literal expectations per directed packet and a narrow-accumulator overflow instance.
module tb_csa_csum_fold;
    localparam int unsigned MaxB = 16384;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csa_csum_fold_if #(.W(32)) bus ();
    csa_csum_fold_if #(.W(32)) bus_s ();

    csa_csum_fold #(.W(32), .ACC_W(48)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    csa_csum_fold #(.W(32), .ACC_W(36)) dut_s (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus_s)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    endtask

    // Packet-level reference: binary total, folded mod 0xFFFF, latency from fold count.
    function automatic longint unsigned beat_val(input logic [31:0] s, input logic [31:0] c);
        return 64'(s) + 64'(c) * 2;
    endfunction

    function automatic int folds(input longint unsigned total);
        longint unsigned t = total;
        longint unsigned x;
        int n = 0;
        while ((t >> 16) != 0) begin
            x = t;
            t = 0;
            while (x != 0) begin
                t += x & 64'hFFFF;
                x >>= 16;
            end
            n++;
        end
        return n;
    endfunction

    function automatic logic [15:0] exp_csum(input longint unsigned total);
        longint unsigned f;
        logic [15:0] c;
        f = (total == 0) ? 0 : ((total - 1) % 65535) + 1;
        c = ~f[15:0];
`ifdef CSA_CSUM_FOLD_ZERO_MAP_EN
        if (c == 16'h0000) c = 16'hFFFF;
`endif
        return c;
    endfunction

    logic            m_rdy, m_ov, m_ovf;
    logic [15:0]     m_csum;
    longint unsigned m_total, m_pend;
    int              m_beats, m_wait;

    always @(posedge clk) begin
        if (rst) begin
            m_rdy <= 1'b1; m_ov <= 1'b0; m_ovf <= 1'b0; m_csum <= 16'h0;
            m_total <= 0; m_pend <= 0; m_beats <= 0; m_wait <= 0;
        end else if (m_rdy) begin
            if (bus.in_valid) begin
                m_total <= m_total + beat_val(bus.in_sum, bus.in_carry);
                m_beats <= m_beats + 1;
                if (bus.in_last) begin
                    m_rdy  <= 1'b0;
                    m_pend <= m_total + beat_val(bus.in_sum, bus.in_carry);
                    m_wait <= folds(m_total + beat_val(bus.in_sum, bus.in_carry));
                end
            end
        end else if (!m_ov) begin
            if (m_wait == 0) begin
                m_ov   <= 1'b1;
                m_csum <= exp_csum(m_pend);
                m_ovf  <= (m_beats > int'(MaxB));
            end else begin
                m_wait <= m_wait - 1;
            end
        end else if (bus.out_ready) begin
            m_ov <= 1'b0; m_rdy <= 1'b1; m_total <= 0; m_beats <= 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
            chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
            if (m_ov) begin
                chk("out_csum", 32'(bus.out_csum), 32'(m_csum));
                chk("out_ovf", 32'(bus.out_ovf), 32'(m_ovf));
            end
        end
    end

    task automatic beat(input logic [31:0] s, input logic [31:0] c, input bit l);
        bus.in_valid = 1'b1; bus.in_sum = s; bus.in_carry = c; bus.in_last = l;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
    endtask

    task automatic wait_out(input string name, input int exp_lat);
        int lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic pkt(input string name, input logic [31:0] s, input logic [31:0] c,
                       input int lat, input logic [15:0] csum);
        beat(s, c, 1'b1);
        wait_out(name, lat);
        chk({name, "_csum"}, 32'(bus.out_csum), 32'(csum));
        chk({name, "_ovf"}, 32'(bus.out_ovf), 32'h0);
        accept();
    endtask

    task automatic beat_s(input bit l);
        bus_s.in_valid = 1'b1; bus_s.in_sum = 32'h1; bus_s.in_last = l;
        @(posedge clk); #1;
        bus_s.in_valid = 1'b0; bus_s.in_last = 1'b0;
    endtask

    task automatic pkt_s(input string name, input int nbeats, input logic [15:0] csum,
                         input logic ovf);
        int lat = 0;
        for (int i = 0; i < nbeats; i++) beat_s(i == nbeats - 1);
        while (!bus_s.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_valid"}, 32'(bus_s.out_valid), 32'h1);
        chk({name, "_csum"}, 32'(bus_s.out_csum), 32'(csum));
        chk({name, "_ovf"}, 32'(bus_s.out_ovf), 32'(ovf));
        bus_s.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_s.out_ready = 1'b0;
        chk({name, "_ready_back"}, 32'(bus_s.in_ready), 32'h1);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_sum = '0; bus.in_carry = '0; bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        bus_s.in_valid = 1'b0; bus_s.in_sum = '0; bus_s.in_carry = '0; bus_s.in_last = 1'b0;
        bus_s.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        started = 1'b1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_csum", 32'(bus.out_csum), 32'h0);
        chk("rst_out_ovf", 32'(bus.out_ovf), 32'h0);
        rst = 1'b0;

        pkt("t1_one", 32'h0000_0001, 32'h0, 1, 16'hFFFE);
        pkt("t2_wrap", 32'hFFFF_FFFF, 32'h8000_0000, 4, 16'hFFFE);
        beat(32'h0000_FFFF, 32'h0, 1'b0);
        pkt("t3_two", 32'h0000_0001, 32'h0, 2, 16'hFFFE);
`ifdef CSA_CSUM_FOLD_ZERO_MAP_EN
        pkt("t4_zero", 32'h0000_FFFF, 32'h0, 1, 16'hFFFF);
`else
        pkt("t4_zero", 32'h0000_FFFF, 32'h0, 1, 16'h0000);
`endif
        pkt("t_carry", 32'h1234_5678, 32'h0001_0001, 2, 16'h974F);

        // Hold the result with out_ready low and confirm nothing moves.
        beat(32'h0000_0002, 32'h0, 1'b1);
        wait_out("t5_hold", 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t5_csum_stable", 32'(bus.out_csum), 32'hFFFD);
            chk("t5_in_ready_low", 32'(bus.in_ready), 32'h0);
        end
        accept();
        chk("t5_in_ready_back", 32'(bus.in_ready), 32'h1);
        chk("t5_valid_drop", 32'(bus.out_valid), 32'h0);

        // Partial packet discarded by reset.
        for (int i = 0; i < 3; i++) beat(32'h0000_0100, 32'h0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_rst_no_out", 32'(bus.out_valid), 32'h0);
        pkt("t6_after_rst", 32'h0000_0001, 32'h0, 1, 16'hFFFE);

        pkt_s("t6_ovf5", 5, 16'hFFFA, 1'b1);
        pkt_s("t6_max4", 4, 16'hFFFB, 1'b0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
